// File: rtl/sevseg_pkg.sv
// Shared seven-segment constants: segment bit positions, all-off / all-on
// patterns and the 16-entry glyph table (0-9 then A,b,C,d,E,F).
// Segment vectors are ordered {a,b,c,d,e,f,g}, a in bit 6.
package sevseg_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_OFF = '0;
    localparam logic [SEG_W-1:0] SEG_ALL = '1;

    localparam logic [SEG_W-1:0] GLYPH_ROM [16] = '{
        7'b1111110, // 0
        7'b0110000, // 1
        7'b1101101, // 2
        7'b1111001, // 3
        7'b0110011, // 4
        7'b1011011, // 5
        7'b1011111, // 6
        7'b1110000, // 7
        7'b1111111, // 8
        7'b1111011, // 9
        7'b1110111, // A
        7'b0011111, // b
        7'b1001110, // C
        7'b0111101, // d
        7'b1001111, // E
        7'b1000111  // F
    };

endpackage

// File: rtl/sevseg_glyph.sv
// Combinational 4-bit code to seven-segment glyph decoder.
// With hex_en low, codes 10-15 decode to an unlit digit.
module sevseg_glyph
    import sevseg_pkg::*;
(
    input  logic [3:0]       code,
    input  logic             hex_en,
    output logic [SEG_W-1:0] glyph
);

    // Table lookup, with the hex range blanked when hex glyphs are disabled
    always_comb begin
        glyph = GLYPH_ROM[code];
        if (!hex_en && (code > 4'd9)) begin
            glyph = SEG_OFF;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver.
// One digit is driven per scan slot; the first GUARD cycles of every slot keep
// all digit enables low so the segment bus can settle without ghosting.
// New digit codes are staged in a pending register and only copied to the
// display register at a frame boundary, so a frame never mixes old and new data.
// Optional decimal points: define SEVSEG_DP_EN to add dp_in / seg_dp.
module seven_seg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 2,
    parameter int HEX_EN   = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  lzs_en,
    input  logic                  lt_n,
    input  logic                  bi_n,
    output logic [SEG_W-1:0]      seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_sync,
    output logic                  all_blank
`ifdef SEVSEG_DP_EN
    ,
    input  logic [DIGITS-1:0]     dp_in,
    output logic                  seg_dp
`endif
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pending;
    logic [4*DIGITS-1:0] display;
    logic                slot_end;
    logic                frame_end;

    logic [DIGITS-1:0]   suppress;
    logic                zero_run;
    logic [3:0]          cur_code;
    logic                cur_supp;
    logic [DIGITS-1:0]   en_next;
    logic [SEG_W-1:0]    dec_glyph;
    logic [SEG_W-1:0]    seg_next;

    assign slot_end  = (cnt == CNT_W'(PRESCALE - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

    // Slot counter and active digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double buffer: pending follows load, display only changes at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            display <= '0;
        end else begin
            if (load) begin
                pending <= digits_in;
            end
            if (frame_end) begin
                display <= pending;
            end
        end
    end

    // Leading-zero mask: digit i is hidden when it and every higher digit are zero
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (display[4*i +: 4] == 4'd0);
            suppress[i] = lzs_en && (i != 0) && zero_run;
        end
    end

    // Select the current digit's code, mask bit and next enable pattern
    always_comb begin
        cur_code = '0;
        cur_supp = 1'b0;
        en_next  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code   = display[4*i +: 4];
                cur_supp   = suppress[i];
                en_next[i] = (cnt >= CNT_W'(GUARD));
            end
        end
    end

    sevseg_glyph u_glyph (
        .code   (cur_code),
        .hex_en (HEX_EN != 0),
        .glyph  (dec_glyph)
    );

    // Glyph priority: blank over lamp test over suppression over decode
    always_comb begin
        seg_next = dec_glyph;
        if (!bi_n) begin
            seg_next = SEG_OFF;
        end else if (!lt_n) begin
            seg_next = SEG_ALL;
        end else if (cur_supp) begin
            seg_next = SEG_OFF;
        end
    end

    // Registered outputs, all one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dig_en     <= '0;
            frame_sync <= 1'b0;
            all_blank  <= 1'b1;
        end else begin
            seg        <= seg_next;
            dig_en     <= en_next;
            frame_sync <= (cnt == '0) && (idx == '0);
            all_blank  <= (display == '0);
        end
    end

`ifdef SEVSEG_DP_EN
    logic [DIGITS-1:0] pending_dp;
    logic [DIGITS-1:0] display_dp;
    logic              cur_dp;

    // Decimal points share the load and frame-boundary timing of the digit codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_dp <= '0;
            display_dp <= '0;
        end else begin
            if (load) begin
                pending_dp <= dp_in;
            end
            if (frame_end) begin
                display_dp <= pending_dp;
            end
        end
    end

    // Current digit's decimal point; leading-zero suppression leaves it alone
    always_comb begin
        cur_dp = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_dp = display_dp[i];
            end
        end
    end

    // Registered decimal point with blank and lamp-test overrides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_dp <= 1'b0;
        end else if (!bi_n) begin
            seg_dp <= 1'b0;
        end else if (!lt_n) begin
            seg_dp <= 1'b1;
        end else begin
            seg_dp <= cur_dp;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with DIGITS=4, PRESCALE=4, GUARD=1, HEX_EN=1.
// The reference derives the scan position from the number of clock edges since
// reset and the glyph from the digit value with shifts and a lookup table.
module tb_seven_seg_scan_driver;

    localparam int D = 4;
    localparam int P = 4;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic        load = 1'b0;
    logic        lzs_en = 1'b0;
    logic        lt_n = 1'b1;
    logic        bi_n = 1'b1;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_sync;
    logic        all_blank;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    int          m_n;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fs;
    logic        e_ab;
    logic [6:0]  tab [16];

    seven_seg_scan_driver #(
        .DIGITS   (D),
        .PRESCALE (P),
        .GUARD    (G),
        .HEX_EN   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .lzs_en     (lzs_en),
        .lt_n       (lt_n),
        .bi_n       (bi_n),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_sync (frame_sync),
        .all_blank  (all_blank)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [15:0] disp, input int i,
                                           input logic lzs, input logic lt, input logic bi);
        logic [15:0] upper;
        upper = disp >> (4 * i);
        if (!bi) return 7'b0000000;
        if (!lt) return 7'b1111111;
        if (lzs && (i > 0) && (upper == 16'd0)) return 7'b0000000;
        return tab[upper[3:0]];
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_pend = '0;
        m_disp = '0;
        e_seg  = '0;
        e_dig  = '0;
        e_fs   = 1'b0;
        e_ab   = 1'b1;
    endtask

    // One clock edge: advance reference with the inputs seen at the edge, then settle
    task automatic tick();
        int cnt;
        int idx;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            cnt   = m_n % P;
            idx   = (m_n / P) % D;
            e_seg = ref_seg(m_disp, idx, lzs_en, lt_n, bi_n);
            e_dig = (cnt >= G) ? 4'(1 << idx) : 4'b0000;
            e_fs  = (cnt == 0) && (idx == 0);
            e_ab  = (m_disp == 16'd0);
            if ((cnt == P - 1) && (idx == D - 1)) m_disp = m_pend;
            if (load) m_pend = digits_in;
            m_n++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors += 4;
        if (seg !== 7'b0000000) begin
            miscompares++;
            $display("FAIL reset_seg: got %b expected 0000000", seg);
        end
        if (dig_en !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_dig_en: got %b expected 0000", dig_en);
        end
        if (frame_sync !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_sync: got %b expected 0", frame_sync);
        end
        if (all_blank !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_all_blank: got %b expected 1", all_blank);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        for (int c = 0; c < 40; c++) begin
            tick();
            vectors += 2;
            if (dig_en !== e_dig) begin
                miscompares++;
                $display("FAIL scan_dig_en n=%0d: got %b expected %b", m_n, dig_en, e_dig);
            end
            if (frame_sync !== e_fs) begin
                miscompares++;
                $display("FAIL scan_frame_sync n=%0d: got %b expected %b", m_n, frame_sync, e_fs);
            end
        end
    endtask

    task automatic run_pattern(input logic [15:0] val, input logic lzs);
        lzs_en    = lzs;
        digits_in = val;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 36; c++) begin
            tick();
            vectors += 2;
            if (seg !== e_seg) begin
                miscompares++;
                $display("FAIL pattern_seg val=%h n=%0d: got %b expected %b", val, m_n, seg, e_seg);
            end
            if (all_blank !== e_ab) begin
                miscompares++;
                $display("FAIL pattern_all_blank val=%h n=%0d: got %b expected %b", val, m_n, all_blank, e_ab);
            end
        end
    endtask

    task automatic test_patterns();
        logic [15:0] v;
        run_pattern(16'h0905, 1'b1);
        run_pattern(16'h0000, 1'b1);
        run_pattern(16'h0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            v = 16'($urandom) >> $urandom_range(0, 15);
            run_pattern(v, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_midframe_load();
        lzs_en    = 1'b1;
        digits_in = 16'h1234;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 34; c++) tick();
        for (int c = 0; c < 16; c++) begin
            if (((m_n / P) % D == 1) && (m_n % P == 1)) break;
            tick();
        end
        digits_in = 16'hABCD;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            vectors++;
            if (seg !== e_seg) begin
                miscompares++;
                $display("FAIL midframe_seg n=%0d: got %b expected %b", m_n, seg, e_seg);
            end
        end
    endtask

    task automatic test_lamp_blank();
        for (int c = 0; c < 48; c++) begin
            lt_n = ($urandom_range(0, 2) != 0);
            bi_n = ($urandom_range(0, 3) != 0);
            if (c < 6) begin
                lt_n = 1'b0;
                bi_n = (c >= 3) ? 1'b0 : 1'b1;
            end
            tick();
            vectors += 2;
            if (seg !== e_seg) begin
                miscompares++;
                $display("FAIL lamp_blank_seg n=%0d: got %b expected %b", m_n, seg, e_seg);
            end
            if (dig_en !== e_dig) begin
                miscompares++;
                $display("FAIL lamp_blank_dig_en n=%0d: got %b expected %b", m_n, dig_en, e_dig);
            end
        end
        lt_n = 1'b1;
        bi_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        lzs_en = 1'($urandom_range(0, 1));
        for (int c = 0; c < 48; c++) begin
            digits_in = 16'($urandom) >> $urandom_range(0, 12);
            load      = 1'b1;
            tick();
            vectors += 2;
            if (seg !== e_seg) begin
                miscompares++;
                $display("FAIL b2b_seg n=%0d: got %b expected %b", m_n, seg, e_seg);
            end
            if (all_blank !== e_ab) begin
                miscompares++;
                $display("FAIL b2b_all_blank n=%0d: got %b expected %b", m_n, all_blank, e_ab);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        found  = 1'b0;
        lzs_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dig_en === 4'b0100) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got dig_en %b expected 0100 within 40 cycles", dig_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (seg !== 7'b0000000) begin
            miscompares++;
            $display("FAIL reset_mid_seg: got %b expected 0000000", seg);
        end
        if (dig_en !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_dig_en: got %b expected 0000", dig_en);
        end
        if (all_blank !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_all_blank: got %b expected 1", all_blank);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 24) begin
                digits_in = 16'h00C7;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            vectors += 3;
            if (seg !== e_seg) begin
                miscompares++;
                $display("FAIL post_reset_seg n=%0d: got %b expected %b", m_n, seg, e_seg);
            end
            if (dig_en !== e_dig) begin
                miscompares++;
                $display("FAIL post_reset_dig_en n=%0d: got %b expected %b", m_n, dig_en, e_dig);
            end
            if (all_blank !== e_ab) begin
                miscompares++;
                $display("FAIL post_reset_all_blank n=%0d: got %b expected %b", m_n, all_blank, e_ab);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        model_reset();
        #1;
        test_reset();
        test_scan();
        test_patterns();
        test_midframe_load();
        test_lamp_blank();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
